// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA object renderer:
//   - descriptor layout (field offsets/widths) and an unpack helper
//   - palette index constants used by the compositor
//   - visible screen limits
// Optional feature macro used by this slice: RENDER_OUTLINE_EN
// -----------------------------------------------------------------------------
package vga_pkg;

  localparam int COORD_W = 10;            // pix_x / pix_y width
  localparam int FIELD_W = 16;            // each descriptor field
  localparam int DESC_W  = 4 * FIELD_W;   // full 64-bit descriptor

  // Descriptor field offsets: {x, y, width, height}, MSB first.
  localparam int X_LSB = 48;
  localparam int Y_LSB = 32;
  localparam int W_LSB = 16;
  localparam int H_LSB = 0;

  localparam logic [COORD_W-1:0] SCREEN_W = 10'd640;
  localparam logic [COORD_W-1:0] SCREEN_H = 10'd480;

  typedef struct packed {
    logic [FIELD_W-1:0] x;
    logic [FIELD_W-1:0] y;
    logic [FIELD_W-1:0] w;
    logic [FIELD_W-1:0] h;
  } obj_desc_t;

  typedef enum logic [2:0] {
    COLOR_BG      = 3'd0,
    COLOR_STAGE   = 3'd1,
    COLOR_P2      = 3'd2,
    COLOR_P1      = 3'd3,
    COLOR_OUTLINE = 3'd4
  } color_e;

  function automatic obj_desc_t unpack_desc(input logic [DESC_W-1:0] raw);
    obj_desc_t d;
    d.x = raw[X_LSB +: FIELD_W];
    d.y = raw[Y_LSB +: FIELD_W];
    d.w = raw[W_LSB +: FIELD_W];
    d.h = raw[H_LSB +: FIELD_W];
    return d;
  endfunction

endpackage

// File: rtl/obj_hit_test.sv
// -----------------------------------------------------------------------------
// obj_hit_test
// Combinational rectangle hit test for one object descriptor.
// Ports:
//   desc     in  64  object descriptor {x, y, width, height}
//   px, py   in  10  pixel coordinate
//   hit      out  1  coordinate lies inside the object
//   on_edge  out  1  coordinate lies on the 1-pixel border (RENDER_OUTLINE_EN only)
// -----------------------------------------------------------------------------
module obj_hit_test
  import vga_pkg::*;
(
  input  logic [DESC_W-1:0]  desc,
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py
`ifdef RENDER_OUTLINE_EN
  ,
  output logic               on_edge
`endif
  ,
  output logic               hit
);

  obj_desc_t          d;
  logic [FIELD_W-1:0] px16;
  logic [FIELD_W-1:0] py16;
  logic [FIELD_W:0]   x_end;   // exclusive right bound, 17 bits so it cannot wrap
  logic [FIELD_W:0]   y_end;   // exclusive bottom bound

  assign d     = unpack_desc(desc);
  assign px16  = {{(FIELD_W-COORD_W){1'b0}}, px};
  assign py16  = {{(FIELD_W-COORD_W){1'b0}}, py};
  assign x_end = {1'b0, d.x} + {1'b0, d.w};
  assign y_end = {1'b0, d.y} + {1'b0, d.h};

  // A zero width or height makes the range empty, so no special case is needed.
  assign hit = (px16 >= d.x) && ({1'b0, px16} < x_end) &&
               (py16 >= d.y) && ({1'b0, py16} < y_end);

`ifdef RENDER_OUTLINE_EN
  logic [FIELD_W:0] x_last;
  logic [FIELD_W:0] y_last;

  // Only consulted while hit is set, which implies w,h >= 1, so no underflow.
  assign x_last  = x_end - (FIELD_W+1)'(1);
  assign y_last  = y_end - (FIELD_W+1)'(1);
  assign on_edge = hit && ((px16 == d.x) || ({1'b0, px16} == x_last) ||
                           (py16 == d.y) || ({1'b0, py16} == y_last));
`endif

endmodule

// File: rtl/vga_object_renderer.sv
// -----------------------------------------------------------------------------
// vga_object_renderer
// Per-pixel compositor for two player sprites and a stage object. Descriptors
// are shadowed on frame_start so CPU writes never tear a frame; each pixel
// passes a 2-stage pipeline (hits, then priority encode) at 1 pixel/cycle.
// Optional feature macro: RENDER_OUTLINE_EN (p1/p2 borders drawn as index 4).
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   frame_start         1-cycle pulse at start of vertical blank
//   pix_valid/x/y       pixel coordinate from the timing generator
//   p1_obj/p2_obj/stage_obj  64-bit object descriptors from the coprocessors
//   color_valid         pix_valid delayed by 2 cycles
//   color_idx           palette index (see vga_pkg::color_e)
//   overlap_last        p1 and p2 overlapped during the previous frame
//   frame_count         frame_start pulses since reset, wrapping
// -----------------------------------------------------------------------------
module vga_object_renderer
  import vga_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic [DESC_W-1:0]  p1_obj,
  input  logic [DESC_W-1:0]  p2_obj,
  input  logic [DESC_W-1:0]  stage_obj,
  output logic               color_valid,
  output logic [2:0]         color_idx,
  output logic               overlap_last,
  output logic [15:0]        frame_count
);

  logic [DESC_W-1:0] p1_sh, p2_sh, st_sh;
  logic              p1_hit, p2_hit, st_hit;
  logic              both_hit;
  logic              ov_acc;

  logic              s1_valid, s1_p1, s1_p2, s1_st;
  color_e            color_next, color_q;

  // NOTE: shadows are deliberately reset to zero: a zero-size descriptor is
  // invisible, which keeps the screen blank until the first frame_start.
  // NOTE: all sequential state uses non-blocking <= so every register samples
  // pre-edge values; this is what makes a same-cycle pixel see the old shadows.
  always_ff @(posedge clock) begin
    if (reset) begin
      p1_sh <= '0;
      p2_sh <= '0;
      st_sh <= '0;
    end else if (frame_start) begin
      p1_sh <= p1_obj;
      p2_sh <= p2_obj;
      st_sh <= stage_obj;
    end
  end

`ifdef RENDER_OUTLINE_EN
  logic p1_edge, p2_edge;
  logic s1_edge;

  obj_hit_test u_hit_p1 (.desc(p1_sh), .px(pix_x), .py(pix_y), .on_edge(p1_edge), .hit(p1_hit));
  obj_hit_test u_hit_p2 (.desc(p2_sh), .px(pix_x), .py(pix_y), .on_edge(p2_edge), .hit(p2_hit));
  obj_hit_test u_hit_st (.desc(st_sh), .px(pix_x), .py(pix_y), .on_edge(),        .hit(st_hit));

  always_ff @(posedge clock) begin
    if (reset) s1_edge <= 1'b0;
    else       s1_edge <= pix_valid && (p1_edge || p2_edge);
  end
`else
  obj_hit_test u_hit_p1 (.desc(p1_sh), .px(pix_x), .py(pix_y), .hit(p1_hit));
  obj_hit_test u_hit_p2 (.desc(p2_sh), .px(pix_x), .py(pix_y), .hit(p2_hit));
  obj_hit_test u_hit_st (.desc(st_sh), .px(pix_x), .py(pix_y), .hit(st_hit));
`endif

  // Stage 1: per-object hits, masked so idle cycles encode as background.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_p1    <= 1'b0;
      s1_p2    <= 1'b0;
      s1_st    <= 1'b0;
    end else begin
      s1_valid <= pix_valid;
      s1_p1    <= pix_valid && p1_hit;
      s1_p2    <= pix_valid && p2_hit;
      s1_st    <= pix_valid && st_hit;
    end
  end

  // NOTE: color_next is assigned a default first, so no path through this
  // block leaves it unassigned and no latch is inferred.
  always_comb begin
    color_next = COLOR_BG;
    if      (s1_p1) color_next = COLOR_P1;
    else if (s1_p2) color_next = COLOR_P2;
    else if (s1_st) color_next = COLOR_STAGE;
`ifdef RENDER_OUTLINE_EN
    if (s1_edge) color_next = COLOR_OUTLINE;
`endif
  end

  // Stage 2: registered palette index.
  always_ff @(posedge clock) begin
    if (reset) begin
      color_valid <= 1'b0;
      color_q     <= COLOR_BG;
    end else begin
      color_valid <= s1_valid;
      color_q     <= color_next;
    end
  end

  assign color_idx = color_q;

  // Overlap is judged at the input side so a hit in the frame_start cycle
  // itself still lands in the frame being closed.
  assign both_hit = pix_valid && p1_hit && p2_hit &&
                    (pix_x < SCREEN_W) && (pix_y < SCREEN_H);

  always_ff @(posedge clock) begin
    if (reset) begin
      ov_acc       <= 1'b0;
      overlap_last <= 1'b0;
      frame_count  <= '0;
    end else if (frame_start) begin
      overlap_last <= ov_acc || both_hit;
      ov_acc       <= 1'b0;
      frame_count  <= frame_count + 16'd1;
    end else if (both_hit) begin
      ov_acc       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_object_renderer.sv
// -----------------------------------------------------------------------------
// tb_vga_object_renderer
// Directed-vector bench for vga_object_renderer. Inputs change 1 time unit
// after the rising edge and outputs are sampled at the same point, so each
// single-pixel probe observes its result two edges after it is applied.
// -----------------------------------------------------------------------------
module tb_vga_object_renderer;

  logic        clock = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        pix_valid;
  logic [9:0]  pix_x, pix_y;
  logic [63:0] p1_obj, p2_obj, stage_obj;
  logic        color_valid;
  logic [2:0]  color_idx;
  logic        overlap_last;
  logic [15:0] frame_count;

  int vectors     = 0;
  int miscompares = 0;

`ifdef RENDER_OUTLINE_EN
  localparam logic [2:0] BORDER_IDX = 3'd4;
`else
  localparam logic [2:0] BORDER_IDX = 3'd3;
`endif

  localparam logic [63:0] P1_BASE  = 64'h0064_0064_0032_0032; // x100 y100 50x50
  localparam logic [63:0] P2_BASE  = 64'h0078_0064_0032_0032; // x120 y100 50x50
  localparam logic [63:0] STAGE    = 64'h0043_0014_01FA_00C8; // x67 y20 506x200

  always #5 clock = ~clock;

  vga_object_renderer dut (
    .clock        (clock),
    .reset        (reset),
    .frame_start  (frame_start),
    .pix_valid    (pix_valid),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .p1_obj       (p1_obj),
    .p2_obj       (p2_obj),
    .stage_obj    (stage_obj),
    .color_valid  (color_valid),
    .color_idx    (color_idx),
    .overlap_last (overlap_last),
    .frame_count  (frame_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Apply one isolated pixel and check its result two edges later.
  task automatic probe(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input logic [2:0] exp);
    pix_valid = 1'b1;
    pix_x     = x;
    pix_y     = y;
    tick();
    pix_valid = 1'b0;
    tick();
    check({tag, "_valid"}, color_valid, 1);
    check(tag, color_idx, exp);
  endtask

  initial begin
    reset       = 1'b1;
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    pix_x       = '0;
    pix_y       = '0;
    p1_obj      = '0;
    p2_obj      = '0;
    stage_obj   = '0;
    repeat (2) tick();
    reset = 1'b0;

    check("rst_color_valid",  color_valid,  0);
    check("rst_color_idx",    color_idx,    0);
    check("rst_overlap_last", overlap_last, 0);
    check("rst_frame_count",  frame_count,  0);

    // Idle after reset: objects invisible, valid appears on the 3rd cycle.
    pix_valid = 1'b1;
    pix_x     = 10'd100;
    pix_y     = 10'd100;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_color_valid", color_valid, (i >= 1));
    end
    check("idle_color_idx",   color_idx,   0);
    check("idle_frame_count", frame_count, 0);
    pix_valid = 1'b0;
    repeat (2) tick();

    // Stage latch and its inclusive/exclusive boundaries.
    stage_obj = STAGE;
    pulse_frame();
    check("fc_after_first", frame_count, 1);
    probe("stage_topleft",  10'd67,  10'd20,  3'd1);
    probe("stage_botright", 10'd572, 10'd219, 3'd1);
    probe("stage_right_ex", 10'd573, 10'd20,  3'd0);
    probe("stage_left_ex",  10'd66,  10'd20,  3'd0);

    // Hold frame_start: each cycle is a pulse. 65535 total reaches 0xFFFF.
    frame_start = 1'b1;
    repeat (65534) @(posedge clock);
    #1;
    check("fc_max", frame_count, 16'hFFFF);
    tick();
    frame_start = 1'b0;
    check("fc_wrap", frame_count, 0);

    // Priority and overlap.
    p1_obj = P1_BASE;
    p2_obj = P2_BASE;
    pulse_frame();
    probe("prio_p1_over_p2", 10'd130, 10'd120, 3'd3);
    probe("prio_p2_only",    10'd160, 10'd120, 3'd2);
    pulse_frame();
    check("overlap_set", overlap_last, 1);
    pulse_frame();
    check("overlap_clear", overlap_last, 0);

    // Descriptor changes without frame_start must not tear.
    p1_obj = 64'h0000_0064_0032_0032;
    probe("no_tear", 10'd130, 10'd120, 3'd3);
    pulse_frame();
    probe("moved_p1", 10'd130, 10'd120, 3'd2);

    // frame_start coincident with a pixel: that pixel uses the old shadows.
    p1_obj = P1_BASE;
    pulse_frame();
    p1_obj      = 64'h0064_0064_0000_0032;  // width 0
    frame_start = 1'b1;
    pix_valid   = 1'b1;
    pix_x       = 10'd130;
    pix_y       = 10'd120;
    tick();
    frame_start = 1'b0;
    tick();
    pix_valid = 1'b0;
    check("same_cycle_old", color_idx, 3);
    tick();
    check("same_cycle_new", color_idx, 2);
    tick();

    // Border pixels of p1 (index 4 only with the outline feature).
    p1_obj = P1_BASE;
    pulse_frame();
    probe("border_tl", 10'd100, 10'd100, BORDER_IDX);
    probe("border_br", 10'd149, 10'd149, BORDER_IDX);
    probe("interior",  10'd101, 10'd101, 3'd3);

    // Reset while streaming.
    pix_valid = 1'b1;
    pix_x     = 10'd130;
    pix_y     = 10'd120;
    repeat (2) tick();
    check("stream_pre_reset", color_idx, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_valid0", color_valid, 0);
    tick();
    check("rst_mid_valid1", color_valid, 0);
    tick();
    check("rst_mid_valid2", color_valid,  1);
    check("rst_mid_idx",    color_idx,    0);
    check("rst_mid_fc",     frame_count,  0);
    check("rst_mid_ovl",    overlap_last, 0);
    pulse_frame();
    tick();
    check("rst_mid_old_shadow", color_idx, 0);
    tick();
    check("rst_mid_reloaded", color_idx,  3);
    check("rst_mid_fc1",      frame_count, 1);
    pix_valid = 1'b0;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_object_renderer.md
# vga_object_renderer

Per-pixel object compositor downstream of the memory-mapped I/O block. Consumes the three 64-bit object descriptors driven out of the VGA coprocessors (player 1, player 2, stage) and, for each pixel coordinate presented by the VGA timing generator, emits a palette index. Descriptors are double-buffered at frame boundaries so CPU writes never tear a frame. It also reports whether the two player sprites overlapped on screen during the previous frame.

## Interface
- No parameters. Widths are fixed in the shared package.
- clock  in  1  system clock, same clock as the MMIO block.
- reset  in  1  synchronous, active-high.
- frame_start  in  1  one-cycle pulse at the start of vertical blank.
- pix_valid  in  1  pix_x/pix_y are a visible pixel this cycle.
- pix_x  in  10  pixel column, 0..639.
- pix_y  in  10  pixel row, 0..479.
- p1_obj  in  64  player 1 descriptor.
- p2_obj  in  64  player 2 descriptor.
- stage_obj  in  64  stage descriptor.
- color_valid  out  1  color_idx is valid; this is pix_valid delayed 2 cycles.
- color_idx  out  3  0 = background, 1 = stage, 2 = player 2, 3 = player 1, 4 = outline (outline only with the macro).
- overlap_last  out  1  p1 and p2 shared at least one visible pixel in the previous completed frame.
- frame_count  out  16  number of frame_start pulses since reset. Wraps.

## Operation
- Descriptor format:
  - [63:48] x, [47:32] y (top-left corner).
  - [31:16] width, [15:0] height.
  - All fields are unsigned.
- Shadow registers: on frame_start, all three inputs are copied into shadow registers. Hit testing uses only the shadows.
- Hit test per object:
  - Condition: (px >= x) and (px < x+w) and (py >= y) and (py < y+h).
  - The sums are 17-bit, so there is no wrap-around.
  - px and py are zero-extended to 16 bits.
  - An object with w=0 or h=0 is never hit.
- Priority: p1 > p2 > stage > background.
- Overlap tracking:
  - The sticky flag ov_acc sets on any valid pixel that hits both p1 and p2.
  - On frame_start: overlap_last <= ov_acc (including a hit in that same cycle), then ov_acc clears.
- frame_count increments on every frame_start. 0xFFFF wraps to 0x0000.

## Timing
- Reset values:
  - Shadows are all 0, so every object is invisible.
  - color_valid=0, color_idx=0, overlap_last=0, frame_count=0.
  - ov_acc=0 and both pipeline stages are cleared.
- Pipeline latency is 2 cycles:
  - Stage 1 registers the per-object hits.
  - Stage 2 registers the priority-encoded color_idx.
  - Throughput is 1 pixel/cycle, with no stalls.
- frame_start and pix_valid in the same cycle: that pixel uses the old shadows. The new shadows apply from the next cycle.
- Reset asserted mid-frame:
  - Any in-flight pixels are dropped, so color_valid=0 for the next 2 cycles.
  - Objects stay invisible until the first frame_start after reset.
- Descriptor inputs changing between frame_start pulses have no visible effect.

## Configuration
- RENDER_OUTLINE_EN defined:
  - A pixel on the 1-pixel border of p1 or p2 emits color_idx=4, taking priority over everything.
  - Border means px==x, px==x+w-1, py==y or py==y+h-1, while inside the object.
  - Objects with w<2 or h<2 are drawn entirely as outline.
- Undefined: index 4 is never produced and latency is unchanged.

## Structure
- Shared package `vga_pkg`:
  - Descriptor field offsets and widths.
  - The color index constants (BG, STAGE, P2, P1, OUTLINE).
  - Screen limits 640x480.
- Sub-module `obj_hit_test`: one descriptor plus a coordinate in; outputs hit, and edge when the macro is defined. It is instantiated three times.

## Test plan
- Reset then idle: pix_valid=1 at (100,100) for 5 cycles -> color_valid=1 from the 3rd cycle, color_idx=0, frame_count=0.
- Latch, boundaries and wrap:
  - Setup: stage_obj=0x0043_0014_01FA_00C8, then a frame_start pulse.
  - Pixel (67,20) -> 1.
  - Pixel (572,219) -> 1.
  - Pixel (573,20) -> 0.
  - Pixel (66,20) -> 0.
  - Then pulse frame_start 65536 times -> frame_count wraps to 0.
- Priority, overlap and tearing:
  - Setup: p1=0x0064_0064_0032_0032, p2=0x0078_0064_0032_0032, frame_start.
  - Pixel (130,120) -> 3.
  - Pixel (160,120) -> 2.
  - Next frame_start -> overlap_last=1.
  - Frame with no pixels, then frame_start -> overlap_last=0.
  - Change p1 to x=0x0000 without a frame_start -> (130,120) still 3.
  - Then frame_start and (130,120) -> 2.
- Same-cycle pulse: frame_start together with pix_valid at (130,120), with p1 changed to w=0 -> that pixel gives 3, the next cycle gives 2.
- Mid-stream reset: 1-cycle reset while pixels are streaming -> color_valid low for 2 cycles after release, then color_idx=0 until frame_start.
- RENDER_OUTLINE_EN with p1 as in the priority scenario:
  - (100,100) -> 4.
  - (149,149) -> 4.
  - (101,101) -> 3.
